// File: rtl/cpu_pkg.sv
// Shared core definitions: exception codes, fixed PCs and the fetch-queue entry layout.
package cpu_pkg;

   localparam logic [4:0]  EXC_NONE = 5'd0;
   localparam logic [4:0]  EXC_ADEL = 5'd4;

   localparam logic [31:0] PC_RESET = 32'h0000_3000;
   localparam logic [31:0] PC_EXC   = 32'h0000_4180;

   // One fetched instruction as it travels from IF to ID (70 bits).
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        delay_slot;
      logic [4:0]  exccode;
   } entry_t;

   // All-zero entry, presented on the dequeue side when nothing is valid.
   function automatic entry_t entry_zero();
      return entry_t'(70'd0);
   endfunction

endpackage

// File: rtl/if_id_queue_fetch_addr_check.sv
// Combinational fetch address check: flags misaligned or out-of-range PCs as AdEL.
module fetch_addr_check
   import cpu_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [31:0] pc_lo,
   input  logic [31:0] pc_hi,
   output logic [4:0]  exccode
);

   // Any of misalignment, below the window or above the window raises AdEL.
   always_comb begin
      if ((pc[1:0] != 2'b00) || (pc < pc_lo) || (pc > pc_hi)) begin
         exccode = EXC_ADEL;
      end else begin
         exccode = EXC_NONE;
      end
   end

endmodule

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: circular buffer of fetched instructions, tagged with AdEL on entry,
// cleared in one cycle by a CP0 flush. enq_ready depends only on registered state.
// Optional macro IF_ID_QUEUE_BYPASS_EN adds a zero-latency path from enq_* to deq_* when empty.
module if_id_queue
   import cpu_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter logic [31:0] PC_LO = 32'h0000_3000,
   parameter logic [31:0] PC_HI = 32'h0000_6ffc
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        enq_valid,
   output logic        enq_ready,
   input  logic [31:0] enq_pc,
   input  logic [31:0] enq_instr,
   input  logic        enq_delay_slot,
   output logic        deq_valid,
   input  logic        deq_ready,
   output logic [31:0] deq_pc,
   output logic [31:0] deq_instr,
   output logic        deq_delay_slot,
   output logic [4:0]  deq_exccode
);

   localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ZERO = AW'(0);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   entry_t          r_mem [DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [AW:0]     r_count;

   logic [4:0]      w_exccode;
   entry_t          w_entry;
   entry_t          w_head;
   logic            w_empty;
   logic            w_full;
   logic            w_bypass;
   logic            w_deq_valid;
   logic            w_enq_fire;
   logic            w_deq_fire;
   logic            w_wr;
   logic            w_rd;

   fetch_addr_check u_addr_check (
      .pc      (enq_pc),
      .pc_lo   (PC_LO),
      .pc_hi   (PC_HI),
      .exccode (w_exccode)
   );

   // Build the entry to store: a faulting fetch carries a nop instead of the fetched word.
   always_comb begin
      w_entry            = entry_zero();
      w_entry.pc         = enq_pc;
      w_entry.delay_slot = enq_delay_slot;
      w_entry.exccode    = w_exccode;
      if (w_exccode != EXC_NONE) begin
         w_entry.instr = 32'd0;
      end else begin
         w_entry.instr = enq_instr;
      end
   end

   assign w_empty   = (r_count == CNT_ZERO);
   assign w_full    = (r_count == FULL_CNT);
   assign enq_ready = ~w_full;

`ifdef IF_ID_QUEUE_BYPASS_EN
   assign w_bypass = w_empty & enq_valid & ~flush;
`else
   assign w_bypass = 1'b0;
`endif

   // Select what the decode stage sees: bypassed entry, stored head, or zeros when empty.
   always_comb begin
      w_head = entry_zero();
      if (w_bypass) begin
         w_head = w_entry;
      end else if (!w_empty) begin
         w_head = r_mem[r_rd_ptr];
      end else begin
         w_head = entry_zero();
      end
   end

   assign w_deq_valid    = ~w_empty | w_bypass;
   assign deq_valid      = w_deq_valid;
   assign deq_pc         = w_head.pc;
   assign deq_instr      = w_head.instr;
   assign deq_delay_slot = w_head.delay_slot;
   assign deq_exccode    = w_head.exccode;

   // Flush overrides both handshakes; a bypassed entry consumed the same cycle is never stored.
   assign w_enq_fire = enq_valid & ~w_full & ~flush;
   assign w_deq_fire = w_deq_valid & deq_ready & ~flush;
   assign w_wr       = w_enq_fire & ~(w_bypass & deq_ready);
   assign w_rd       = w_deq_fire & ~w_bypass;

   // Pointer and occupancy bookkeeping, cleared by reset or flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= PTR_ZERO;
         r_rd_ptr <= PTR_ZERO;
         r_count  <= CNT_ZERO;
      end else if (flush) begin
         r_wr_ptr <= PTR_ZERO;
         r_rd_ptr <= PTR_ZERO;
         r_count  <= CNT_ZERO;
      end else begin
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end else begin
            r_wr_ptr <= r_wr_ptr;
         end
         if (w_rd) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end else begin
            r_rd_ptr <= r_rd_ptr;
         end
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // Entry storage; written at the write pointer on an accepted, non-bypassed enqueue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_mem[i] <= entry_zero();
         end
      end else if (w_wr) begin
         r_mem[r_wr_ptr] <= w_entry;
      end else begin
         r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
      end
   end

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: FIFO scoreboard fed by a driver-side reference model,
// compared by an independent monitor. Honours IF_ID_QUEUE_BYPASS_EN when defined.
module tb_if_id_queue;
   import cpu_pkg::*;

   localparam int          DEPTH = 2;
   localparam logic [31:0] LO    = 32'h0000_3000;
   localparam logic [31:0] HI    = 32'h0000_6ffc;
`ifdef IF_ID_QUEUE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk, rst_n, flush, enq_valid, enq_ready, enq_delay_slot;
   logic [31:0] enq_pc, enq_instr;
   logic        deq_valid, deq_ready, deq_delay_slot;
   logic [31:0] deq_pc, deq_instr;
   logic [4:0]  deq_exccode;

   if_id_queue #(.DEPTH(DEPTH), .PC_LO(LO), .PC_HI(HI)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_pc(enq_pc),
      .enq_instr(enq_instr), .enq_delay_slot(enq_delay_slot),
      .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_pc(deq_pc),
      .deq_instr(deq_instr), .deq_delay_slot(deq_delay_slot), .deq_exccode(deq_exccode)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int     n_checks = 0;
   int     n_errors = 0;
   entry_t exp_q[$];
   entry_t pend_e;
   bit     pend_push;
   bit     exp_rdy = 1'b1;

   // Reference rule: an entry is AdEL when misaligned or outside [LO, HI]; AdEL entries carry a nop.
   function automatic entry_t ref_entry(logic [31:0] pc, logic [31:0] ins, logic ds);
      entry_t e;
      bit bad;
      bad = (pc % 4 != 0) || (pc < LO) || (pc > HI);
      e.pc = pc;
      e.delay_slot = ds;
      e.exccode = bad ? 5'd4 : 5'd0;
      e.instr = bad ? 32'd0 : ins;
      return e;
   endfunction

   task automatic chk(string nm, logic [71:0] act, logic [71:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Driver-side model: decide acceptance from the model's own occupancy and push expectations.
   initial forever begin
      entry_t e;
      @(negedge clk);
      pend_push = 1'b0;
      if (!rst_n) begin
         exp_q.delete();
         exp_rdy = 1'b1;
      end else begin
         exp_rdy = (exp_q.size() != DEPTH);
         if (!flush && enq_valid && exp_rdy) begin
            e = ref_entry(enq_pc, enq_instr, enq_delay_slot);
            if (BYP && exp_q.size() == 0) begin
               exp_q.push_back(e);
            end else begin
               pend_push = 1'b1;
               pend_e = e;
            end
         end
      end
      @(posedge clk);
      if (rst_n) begin
         if (flush) exp_q.delete();
         else if (pend_push) exp_q.push_back(pend_e);
      end
   end

   // Monitor: compare what the DUT presents with the scoreboard head; pop on consumption.
   initial forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
         chk("rst_deq_valid", 72'(deq_valid), 72'd0);
         chk("rst_enq_ready", 72'(enq_ready), 72'd1);
         chk("rst_deq_data", 72'({deq_pc, deq_instr, deq_delay_slot, deq_exccode}), 72'd0);
      end else begin
         chk("enq_ready", 72'(enq_ready), 72'(exp_rdy));
         if (exp_q.size() > 0) begin
            chk("deq_valid", 72'(deq_valid), 72'd1);
            chk("deq_head", 72'({deq_pc, deq_instr, deq_delay_slot, deq_exccode}), 72'(exp_q[0]));
            if (deq_ready && !flush) void'(exp_q.pop_front());
         end else begin
            chk("deq_idle_valid", 72'(deq_valid), 72'd0);
            chk("deq_idle_data", 72'({deq_pc, deq_instr, deq_delay_slot, deq_exccode}), 72'd0);
         end
      end
   end

   task automatic cyc(bit fl, bit ev, logic [31:0] pc, logic [31:0] ins, bit ds, bit dr);
      @(posedge clk);
      #1;
      flush = fl; enq_valid = ev; enq_pc = pc; enq_instr = ins;
      enq_delay_slot = ds; deq_ready = dr;
   endtask

   task automatic idle(int n, bit dr);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, dr);
   endtask

   function automatic logic [31:0] rand_pc();
      case ($urandom_range(0, 5))
         0: return LO - 32'd4;
         1: return LO;
         2: return HI;
         3: return HI + 32'd4;
         4: return (LO + 32'($urandom_range(0, 32'h3fff) * 4)) | 32'($urandom_range(1, 3));
         default: return LO + 32'($urandom_range(0, 32'h0fff) * 4);
      endcase
   endfunction

   initial begin
      rst_n = 1'b0; flush = 1'b0; enq_valid = 1'b0; enq_pc = 32'd0;
      enq_instr = 32'd0; enq_delay_slot = 1'b0; deq_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Basic single transfer
      cyc(1'b0, 1'b1, 32'h3000, 32'h2401_0001, 1'b0, 1'b1);
      idle(2, 1'b1);

      // Fill to full with decode stalled; third fetch is held until a slot frees
      cyc(1'b0, 1'b1, 32'h3000, 32'h1111_0000, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 32'h3004, 32'h1111_0004, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 32'h3008, 32'h1111_0008, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 32'h3008, 32'h1111_0008, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 32'h3008, 32'h1111_0008, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 32'h3008, 32'h1111_0008, 1'b0, 1'b1);
      idle(3, 1'b1);

      // Address checks at the window boundaries
      cyc(1'b0, 1'b1, 32'h3002, 32'hdead_beef, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 32'h7000, 32'hdead_beef, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 32'h6ffc, 32'h0000_0021, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 32'h2ffc, 32'h0000_0022, 1'b1, 1'b1);
      idle(2, 1'b1);

      // Full, then flush with a concurrent enqueue that must be dropped
      cyc(1'b0, 1'b1, 32'h3100, 32'h0000_0100, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 32'h3104, 32'h0000_0104, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 32'h3108, 32'h0000_0108, 1'b0, 1'b1);
      idle(2, 1'b1);

      // Delay-slot entry, then asynchronous reset between clock edges
      cyc(1'b0, 1'b1, 32'h3040, 32'h0000_0040, 1'b1, 1'b0);
      @(posedge clk);
      #1 enq_valid = 1'b0;
      #1 chk("ds_entry_visible", 72'({deq_valid, deq_delay_slot}), 72'd3);
      #1 rst_n = 1'b0;
      exp_q.delete();
      #1 chk("async_rst_valid", 72'(deq_valid), 72'd0);
      chk("async_rst_ready", 72'(enq_ready), 72'd1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      cyc(1'b0, 1'b1, 32'h3000, 32'h2401_0001, 1'b0, 1'b1);
      idle(2, 1'b1);

      // Empty-queue fetch with decode ready (zero-latency when bypass is built in)
      cyc(1'b0, 1'b1, 32'h3010, 32'h0000_0010, 1'b0, 1'b1);
      idle(2, 1'b1);

      // Randomised traffic
      for (int i = 0; i < 600; i++) begin
         cyc(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), rand_pc(),
             $urandom(), 1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0));
      end
      idle(4, 1'b1);
      @(negedge clk);
      #3;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Decoupling queue between the instruction fetch unit and the decode stage of the pipelined MIPS core. Each accepted entry carries the fetched PC, instruction word and delay-slot flag. On entry it is tagged with an address-error exception code (AdEL) if the PC is misaligned or outside instruction memory. The queue absorbs decode stalls without back-pressuring the PC register combinationally, and empties in one cycle on a CP0 exception/ERET flush.

## Interface
- DEPTH, 2: number of entries; power of two, ≥2.
- PC_LO, 32'h0000_3000: lowest legal instruction address.
- PC_HI, 32'h0000_6ffc: highest legal instruction address (inclusive).
- clk  in  1  pipeline clock.
- rst_n  in  1  reset: asynchronous assertion, active-low; one clock, no other clock domains.
- flush  in  1  CP0 Req/ERET redirect; discards all entries.
- enq_valid  in  1  IFU presents a fetched instruction.
- enq_ready  out  1  queue can accept an entry this cycle.
- enq_pc  in  32  PC of the fetched instruction.
- enq_instr  in  32  instruction word.
- enq_delay_slot  in  1  instruction sits in a branch delay slot.
- deq_valid  out  1  head entry is valid.
- deq_ready  in  1  decode consumes the head entry this cycle.
- deq_pc  out  32  head PC.
- deq_instr  out  32  head instruction; 0 (nop) when deq_exccode is nonzero.
- deq_delay_slot  out  1  head delay-slot flag.
- deq_exccode  out  5  0 = none, 4 = AdEL.

## Operation
- Storage: circular buffer with wr_ptr and rd_ptr of log2(DEPTH) bits each, plus a count of log2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- Enqueue fires on enq_valid && enq_ready. Dequeue fires on deq_valid && deq_ready.
- enq_ready = (count != DEPTH). It depends only on registered state; there is no path from deq_ready.
- Address check at enqueue: the entry is AdEL if enq_pc[1:0] != 0, enq_pc < PC_LO, or enq_pc > PC_HI.
  - On AdEL, the stored instruction is 0 and exccode is 4. PC and delay-slot flag are stored unchanged.
- Simultaneous enqueue and dequeue while neither empty nor full: count is unchanged and both pointers advance.
- Full (count == DEPTH): enq_ready = 0, so no write is possible even if deq_ready is high. The slot frees on the next cycle.
- Empty (count == 0): deq_valid = 0 and deq_pc, deq_instr, deq_delay_slot, deq_exccode all read 0.
- flush takes priority over enqueue and dequeue in the same cycle. Pointers and count are cleared, and any enqueue in that cycle is dropped.
- Reset (rst_n low, at any time, including mid-transfer): pointers and count are cleared immediately. Outputs: deq_valid 0, enq_ready 1, all deq data outputs 0.

## Timing
- Base latency: an entry enqueued at edge N is visible on deq_* after edge N and can be consumed at edge N+1.
- flush asserted in cycle N: deq_valid = 0 and enq_ready = 1 after edge N. The first post-redirect fetch can be enqueued in cycle N+1.
- Throughput: one entry per cycle sustained while not full.
- All outputs are functions of registered state only, except in bypass mode (see Configuration).

## Configuration
- IF_ID_QUEUE_BYPASS_EN defined:
  - When count == 0, enq_valid = 1 and flush = 0, the incoming entry (after the address check) is driven on deq_* in the same cycle with deq_valid = 1.
  - If deq_ready is also high, the entry is consumed and not written.
  - This gives a zero-cycle latency path from enq_* to deq_*.
- IF_ID_QUEUE_BYPASS_EN undefined: minimum latency is one cycle, as described under Timing.

## Structure
- Shared package cpu_pkg holds:
  - EXC_NONE = 5'd0 and EXC_ADEL = 5'd4;
  - PC_RESET = 32'h0000_3000 and PC_EXC = 32'h0000_4180;
  - the packed entry typedef {pc, instr, delay_slot, exccode} (70 bits).
- One sub-module, fetch_addr_check: combinational, takes PC, PC_LO and PC_HI, and produces exccode.

## Test plan
- Reset then enqueue pc 0x3000, instr 0x24010001 with deq_ready = 1 → cycle+1: deq_valid 1, deq_pc 0x3000, deq_instr 0x24010001, deq_exccode 0.
- Enqueue 0x3000, 0x3004, 0x3008 with deq_ready = 0 and DEPTH 2 → enq_ready drops after the second accept. Third is held until a dequeue. Output order is 0x3000, 0x3004, 0x3008.
- Enqueue pc 0x3002 → deq_exccode 4, deq_instr 0. Enqueue pc 0x7000 → deq_exccode 4. Enqueue pc 0x6ffc → deq_exccode 0.
- Queue full, then flush asserted together with enq_valid → next cycle count 0, deq_valid 0, enq_ready 1. The enqueued entry is dropped.
- Enqueue with delay_slot = 1, then drop rst_n mid-cycle → deq_valid 0 immediately, before the clock edge. After release, behaviour matches the first scenario.
- With IF_ID_QUEUE_BYPASS_EN: empty queue, enq pc 0x3010, deq_ready = 1 → same cycle deq_valid 1, deq_pc 0x3010, and count stays 0.
